// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: APC window FSM states, default
// stream length, and the ReLU/saturate helper reused by downstream layers.
// No ports; import with sc_pkg::*.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } apc_state_e;

  localparam int SC_WIN_LEN = 16;

  // Non-positive sums map to 0. Positive sums are arithmetically shifted,
  // then clamped to the largest out_w-bit value.
  function automatic logic [15:0] sat_relu(input logic signed [31:0] sum,
                                           input int shift,
                                           input int out_w);
    logic signed [31:0] shifted;
    int                 max_val;
    max_val = (1 << out_w) - 1;
    shifted = sum >>> shift;
    if (sum <= 0) return '0;
    if (shifted > max_val) return max_val[15:0];
    return shifted[15:0];
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Purpose: combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_vec (W bits in), o_cnt (number of set bits, $clog2(W+1) bits).
module sc_popcount #(
  parameter int W = 9
) (
  input  logic [W-1:0]           i_vec,
  output logic [$clog2(W+1)-1:0] o_cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/sc_apc_accumulator.sv
// Purpose: AND-multiply N_IN stochastic lanes, signed-popcount them, and
//   accumulate over a WIN_LEN-cycle window; emit signed sum + ReLU/sat act.
// Latency: result registered 1 edge after the last sample edge.
// Backpressure: none; o_valid is a one-cycle strobe, and a start in DRAIN
//   chains windows back-to-back without losing samples.
// Ports: i_clk_apc/i_rst_n_apc (async active-low), i_start_apc, i_stop_apc,
//   i_x_sn/i_w_sn/i_w_sign lanes; o_busy, o_valid, o_sum (signed), o_act.
module sc_apc_accumulator
  import sc_pkg::*;
#(
  parameter int N_IN    = 9,
  parameter int WIN_LEN = SC_WIN_LEN,
  parameter int OUT_W   = 4,
  parameter int SHIFT   = 4,
  parameter int ACC_W   = $clog2(WIN_LEN * N_IN + 1) + 1
) (
  input  logic                    i_clk_apc,
  input  logic                    i_rst_n_apc,
  input  logic                    i_start_apc,
  input  logic                    i_stop_apc,
  input  logic [N_IN-1:0]         i_x_sn,
  input  logic [N_IN-1:0]         i_w_sn,
  input  logic [N_IN-1:0]         i_w_sign,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] o_sum,
  output logic [OUT_W-1:0]        o_act
);

  localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int PC_W  = $clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

  apc_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] d1_q, d1_d;
  logic                    d1_v_q, d1_v_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [OUT_W-1:0]        act_q, act_d;

  logic [N_IN-1:0]         prod_pos, prod_neg;
  logic [PC_W-1:0]         pos_cnt, neg_cnt;
  logic signed [ACC_W-1:0] sample_diff;
  logic signed [ACC_W-1:0] sum_fin;

  assign prod_pos = i_x_sn & i_w_sn & ~i_w_sign;
  assign prod_neg = i_x_sn & i_w_sn & i_w_sign;

  sc_popcount #(.W(N_IN)) u_pc_pos (.i_vec(prod_pos), .o_cnt(pos_cnt));
  sc_popcount #(.W(N_IN)) u_pc_neg (.i_vec(prod_neg), .o_cnt(neg_cnt));

  assign sample_diff = ACC_W'(pos_cnt) - ACC_W'(neg_cnt);
  // The last sample is still in d1 when DRAIN is reached, so fold it in here.
  assign sum_fin     = acc_q + d1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    d1_d    = d1_q;
    d1_v_d  = d1_v_q;
    sum_d   = sum_q;
    act_d   = act_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start_apc) begin
          state_d = ACC;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (i_stop_apc) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          d1_v_d  = 1'b0;
        end else begin
          d1_d   = sample_diff;
          d1_v_d = 1'b1;
          if (d1_v_q) acc_d = acc_q + d1_q;
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        sum_d   = sum_fin;
        act_d   = OUT_W'(sat_relu(32'(sum_fin), SHIFT, OUT_W));
        valid_d = 1'b1;
        acc_d   = '0;
        d1_v_d  = 1'b0;
        cnt_d   = '0;
        state_d = i_start_apc ? ACC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_apc or negedge i_rst_n_apc) begin
    if (!i_rst_n_apc) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      d1_q    <= '0;
      d1_v_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      d1_q    <= d1_d;
      d1_v_q  <= d1_v_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      act_q   <= act_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_act   = act_q;

endmodule

// File: tb/tb_sc_apc_accumulator.sv
// Purpose: scoreboard bench for sc_apc_accumulator; two instances share the
//   control inputs (9 lanes/SHIFT 4 and 32 lanes/SHIFT 0).
// Expected window results come from a lane-by-lane arithmetic model.
module tb_sc_apc_accumulator;

  localparam int WIN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] w = '0;
  logic [31:0] sg = '0;

  logic              busy0, valid0, busy1, valid1;
  logic signed [8:0] sum0;
  logic signed [10:0] sum1;
  logic [3:0]        act0, act1;

  always #5 clk = ~clk;

  sc_apc_accumulator #(.N_IN(9)) dut0 (
    .i_clk_apc(clk), .i_rst_n_apc(rst_n), .i_start_apc(start), .i_stop_apc(stop),
    .i_x_sn(x[8:0]), .i_w_sn(w[8:0]), .i_w_sign(sg[8:0]),
    .o_busy(busy0), .o_valid(valid0), .o_sum(sum0), .o_act(act0)
  );

  sc_apc_accumulator #(.N_IN(32), .SHIFT(0)) dut1 (
    .i_clk_apc(clk), .i_rst_n_apc(rst_n), .i_start_apc(start), .i_stop_apc(stop),
    .i_x_sn(x), .i_w_sn(w), .i_w_sign(sg),
    .o_busy(busy1), .o_valid(valid1), .o_sum(sum1), .o_act(act1)
  );

  typedef struct {
    int s0;
    int a0;
    int s1;
    int a1;
    int edge_no;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   last_s0 = 0, last_a0 = 0, last_s1 = 0, last_a1 = 0;
  int   nxt_e = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, req, $time);
    end
  endfunction

  // Reference: each lane with x&w contributes +1, or -1 when its sign is set.
  function automatic int lane_sum(input logic [31:0] xv, input logic [31:0] wv,
                                  input logic [31:0] sv, input int n);
    int r = 0;
    for (int i = 0; i < n; i++)
      if (xv[i] && wv[i]) r += sv[i] ? -1 : 1;
    return r;
  endfunction

  function automatic int relu_sat(input int s, input int sh);
    int v;
    if (s <= 0) return 0;
    v = s >>> sh;
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: pops the scoreboard on every strobe, otherwise checks outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid0 || valid1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", int'(valid0 | valid1), 0);
        end else begin
          e = q.pop_front();
          chk("valid0", int'(valid0), 1);
          chk("valid1", int'(valid1), 1);
          chk("sum0", int'(sum0), e.s0);
          chk("act0", int'(act0), e.a0);
          chk("sum1", int'(sum1), e.s1);
          chk("act1", int'(act1), e.a1);
          chk("valid_edge", edge_cnt, e.edge_no);
          last_s0 = e.s0; last_a0 = e.a0; last_s1 = e.s1; last_a1 = e.a1;
        end
      end else begin
        chk("held_sum0", int'(sum0), last_s0);
        chk("held_act0", int'(act0), last_a0);
        chk("held_sum1", int'(sum1), last_s1);
        chk("held_act1", int'(act1), last_a1);
      end
    end
  end

  // mode 0: all ones; 1: all ones, all negative; 2: lane0 half-density; 3: random
  task automatic run_window(input int mode, input bit started, input bit b2b,
                            input int stop_at);
    int          s0 = 0, s1 = 0, e;
    logic [31:0] sgn;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
      stop  = 1'($urandom_range(0, 1));   // start must win over stop in IDLE
      x = $urandom; w = $urandom; sg = $urandom;
      e = edge_cnt + 1;
    end else begin
      e = nxt_e;
    end
    sgn = (mode == 1) ? 32'hFFFF_FFFF : (mode == 3) ? 32'($urandom) : 32'h0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (k == 0) begin
        chk("busy0_acc", int'(busy0), 1);
        chk("busy1_acc", int'(busy1), 1);
      end
      sg = sgn;
      case (mode)
        0, 1:    begin x = 32'hFFFF_FFFF; w = 32'hFFFF_FFFF; end
        2:       begin x = (k % 2 == 0) ? 32'h1 : 32'h0; w = 32'h1; end
        default: begin x = $urandom; w = $urandom; end
      endcase
      if (k == stop_at) begin
        stop = 1'b1;
        start = 1'b1;        // ignored while accumulating
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        chk("busy0_after_stop", int'(busy0), 0);
        chk("busy1_after_stop", int'(busy1), 0);
        return;
      end
      s0 += lane_sum(x, w, sgn, 9);
      s1 += lane_sum(x, w, sgn, 32);
    end
    @(negedge clk);              // DRAIN cycle; stream bits here are not sampled
    chk("busy0_drain", int'(busy0), 1);
    start = b2b;
    stop  = 1'($urandom_range(0, 1));   // no effect in DRAIN
    x = $urandom; w = $urandom;
    q.push_back('{s0, relu_sat(s0, 4), s1, relu_sat(s1, 0), e + WIN + 1});
    if (b2b) nxt_e = edge_cnt + 1;
    if (!b2b) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("busy0_idle", int'(busy0), 0);
      chk("busy1_idle", int'(busy1), 0);
    end
  endtask

  task automatic reset_mid_window();
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      x = $urandom; w = $urandom; sg = '0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_valid0", int'(valid0), 0);
    chk("rst_sum0", int'(sum0), 0);
    chk("rst_act0", int'(act0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_sum1", int'(sum1), 0);
    last_s0 = 0; last_a0 = 0; last_s1 = 0; last_a1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit prev, nb;
    repeat (3) @(negedge clk);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_valid0", int'(valid0), 0);
    chk("reset_sum0", int'(sum0), 0);
    chk("reset_act0", int'(act0), 0);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_sum1", int'(sum1), 0);
    rst_n = 1'b1;

    run_window(0, 1'b0, 1'b0, -1);   // 144/9 and 512/15 (saturated)
    run_window(1, 1'b0, 1'b0, -1);   // -144/0
    run_window(2, 1'b0, 1'b0, -1);   // 8/0 and 8/8
    run_window(3, 1'b0, 1'b1, -1);   // back-to-back chain
    run_window(3, 1'b1, 1'b0, -1);
    run_window(0, 1'b0, 1'b1, -1);
    run_window(3, 1'b1, 1'b1, -1);
    run_window(1, 1'b1, 1'b0, -1);
    run_window(3, 1'b0, 1'b0, 7);    // abort at sample 7
    run_window(0, 1'b0, 1'b0, -1);
    reset_mid_window();
    run_window(3, 1'b0, 1'b0, -1);

    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nb = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      run_window(3, prev, nb, (!prev && !nb && i == 3) ? 10 : -1);
      prev = nb;
    end

    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
